fifo_rd_stream: RTL

- Read-side adapter placed directly downstream of the team's synchronous FIFO.
- Drains the FIFO's `ren`/`empty`/`data_out` interface and presents a registered valid/ready stream to the consumer.
- Holds up to two beats in a 2-entry output skid stage. This sustains one beat per cycle without a combinational path from `m_ready` to the FIFO read enable.
- An optional flush discards everything buffered and drains the FIFO.

---
 rtl/fifo_pkg.sv | 16 +
 rtl/stream_skid_buf.sv | 75 +++++++
 rtl/fifo_rd_stream.sv | 64 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-side stream adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_pkg;

    // Occupancy of the 2-entry output skid stage.
    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_state_e;

    // Default width of the optional accepted-beat counter.
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// 2-entry skid stage: head register feeds the output, skid holds a second beat.
// Latency: a pushed beat appears on head one cycle later when the stage was empty.
// Backpressure: absorbs one extra beat while the consumer stalls; owner must not push in TWO.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter type T = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  T           push_data,
    input  logic       hs,
    output occ_state_e state,
    output T           head
);

    occ_state_e state_nxt;
    T           head_nxt;
    T           skid;
    T           skid_nxt;

    // Occupancy and data-path next-state decode.
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        if (flush) begin
            // Buffered beats are dropped; register contents are don't-care once EMPTY.
            state_nxt = OCC_EMPTY;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        head_nxt  = push_data;
                        state_nxt = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && hs) begin
                        head_nxt = push_data;
                    end else if (push) begin
                        skid_nxt  = push_data;
                        state_nxt = OCC_TWO;
                    end else if (hs) begin
                        state_nxt = OCC_EMPTY;
                    end
                end
                OCC_TWO: begin
                    // The owner never pushes here, so only a handshake moves the stage.
                    if (hs) begin
                        head_nxt  = skid;
                        state_nxt = OCC_ONE;
                    end
                end
                default: state_nxt = OCC_EMPTY;
            endcase
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OCC_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            skid  <= skid_nxt;
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side adapter: pops ren/empty/data FIFO into a registered valid/ready stream (optional beat counter: FIFO_RD_STREAM_CNT_EN).
// Latency: FIFO head to m_data in 1 cycle; sustains 1 beat/cycle with m_ready held high.
// Backpressure: at most 2 beats popped beyond the last handshake; m_ready never reaches fifo_ren combinationally.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter type T     = logic,
    parameter int  CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             fifo_empty,
    input  T                 fifo_data,
    output logic             fifo_ren,
    output logic             m_valid,
    input  logic             m_ready,
    output T                 m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] beat_cnt
`endif
);

    occ_state_e state;
    logic       hs;
    logic       push;

    // Valid is a pure decode of registered occupancy, so it has no input dependence.
    assign m_valid = (state != OCC_EMPTY);
    assign hs      = m_valid && m_ready;

    // Pop whenever there is room, or unconditionally while flushing to drain the FIFO.
    assign fifo_ren = !rst && !fifo_empty && (flush || (state != OCC_TWO));
    // Beats popped during a flush are discarded rather than buffered.
    assign push     = fifo_ren && !flush;

    stream_skid_buf #(
        .T (T)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (fifo_data),
        .hs        (hs),
        .state     (state),
        .head      (m_data)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    // Accepted-beat counter; flush wins over a coincident handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            beat_cnt <= '0;
        end else if (hs) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule
